vc_spi_mem_ctrl: RTL and testbench

- SPI memory controller between the vc CPU's physical memory port (PA-bit addresses from the MMU) and the external flash and PSRAM reached over the tile's uio pins.
- Accepts one read or write request at a time over a valid/ready handshake.
- Serialises each request as a standard SPI mode-0 transaction (0x03 read / 0x02 write, 24-bit address) and returns a single-cycle response.
- Physical address bit 21 selects the device: 0 = flash, 1 = PSRAM.

---
 rtl/vc_spi_mem_ctrl.sv | 151 +++++++++++++++
 tb/tb_vc_spi_mem_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_spi_mem_ctrl.sv
// vc_spi_mem_ctrl: SPI mode-0 bridge from the vc physical memory port
// to the external flash (cs_n[0]) and PSRAM (cs_n[1]).
module vc_spi_mem_ctrl #(
  parameter int PA      = 22,
  parameter int CLK_DIV = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic          req_size,
  input  logic [PA-1:0] req_addr,
  input  logic [15:0]   req_wdata,
  output logic          resp_valid,
  output logic [15:0]   resp_rdata,
  output logic          spi_sck,
  output logic          spi_mosi,
  input  logic          spi_miso,
  output logic [1:0]    spi_cs_n
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  localparam logic [3:0] HMAX = 4'(CLK_DIV - 1);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  half_cnt;
  logic [5:0]  bit_cnt;
  logic [47:0] tx_sr;
  logic [15:0] rx_sr;
  logic        rd_q;
  logic        word_q;

  logic        accept;
  logic        drop;
  logic        start;
  logic        tick;
  logic        last_fall;
  logic        gap_end;
  logic [5:0]  last_bit;
  logic [23:0] addr24;
  logic [47:0] tx_init;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign drop      = accept && req_write && !req_addr[PA-1];
  assign start     = accept && !drop;
  assign tick      = (half_cnt == HMAX);
  assign last_bit  = word_q ? 6'd47 : 6'd39;
  assign last_fall = (state == SHIFT) && tick && spi_sck
                     && (bit_cnt == last_bit);
  assign gap_end   = (state == GAP) && tick;
  assign spi_mosi  = tx_sr[47];

  // Frame: cmd, 24-bit addr, then data (low byte first for words).
  always_comb begin
    addr24 = 24'(req_addr[PA-2:0]);
    if (req_size) addr24[0] = 1'b0;
    tx_init = {(req_write ? 8'h02 : 8'h03), addr24, 16'h0000};
    if (req_write) begin
      tx_init[15:0] = req_size ? {req_wdata[7:0], req_wdata[15:8]}
                               : {req_wdata[7:0], 8'h00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start)     state_nx = SHIFT;
      SHIFT:   if (last_fall) state_nx = GAP;
      GAP:     if (gap_end)   state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt   <= '0;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rd_q       <= 1'b0;
      word_q     <= 1'b0;
      spi_sck    <= 1'b0;
      spi_cs_n   <= 2'b11;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (drop) resp_valid <= 1'b1;
          if (start) begin
            spi_cs_n <= req_addr[PA-1] ? 2'b01 : 2'b10;
            tx_sr    <= tx_init;
            rx_sr    <= '0;
            rd_q     <= !req_write;
            word_q   <= req_size;
            bit_cnt  <= '0;
            half_cnt <= '0;
            spi_sck  <= 1'b0;
          end
        end
        SHIFT: begin
          if (!tick) begin
            half_cnt <= half_cnt + 4'd1;
          end else begin
            half_cnt <= '0;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
              if (rd_q && bit_cnt >= 6'd32)
                rx_sr <= {rx_sr[14:0], spi_miso};
            end else begin
              spi_sck <= 1'b0;
              tx_sr   <= {tx_sr[46:0], 1'b0};
              if (bit_cnt == last_bit) begin
                spi_cs_n   <= 2'b11;
                resp_valid <= 1'b1;
                tx_sr      <= '0;
                if (rd_q)
                  resp_rdata <= word_q ? {rx_sr[7:0], rx_sr[15:8]}
                                       : {8'h00, rx_sr[7:0]};
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end
        end
        GAP: begin
          half_cnt <= tick ? 4'd0 : half_cnt + 4'd1;
        end
        default: begin
          spi_cs_n <= 2'b11;
          spi_sck  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vc_spi_mem_ctrl.sv
// Bench for vc_spi_mem_ctrl: two instances (CLK_DIV 1 and 2), SPI slave
// model, response scoreboard, vector table and reset corner cases.
module tb_vc_spi_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic        req_size   [2];
  logic [21:0] req_addr   [2];
  logic [15:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [15:0] resp_rdata [2];
  logic        spi_sck    [2];
  logic        spi_mosi   [2];
  logic        spi_miso   [2];
  logic [1:0]  spi_cs_n   [2];

  vc_spi_mem_ctrl #(.PA(22), .CLK_DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .spi_sck(spi_sck[0]), .spi_mosi(spi_mosi[0]),
    .spi_miso(spi_miso[0]), .spi_cs_n(spi_cs_n[0])
  );

  vc_spi_mem_ctrl #(.PA(22), .CLK_DIV(2)) u_div2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .spi_sck(spi_sck[1]), .spi_mosi(spi_mosi[1]),
    .spi_miso(spi_miso[1]), .spi_cs_n(spi_cs_n[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          d;
    logic        wr;
    logic        sz;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic [47:0] miso;
    logic [15:0] rdata;
    logic [1:0]  cs;
    int          nbits;
    logic [47:0] mosi;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [15:0] rdata;
    logic        ready;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  logic [47:0] stream     [2];
  logic [47:0] mosi_bits  [2];
  int          rise_cnt   [2];
  int          resp_cnt   [2];
  logic        prev_sck   [2];
  logic [1:0]  cs_and     [2];
  logic        ready_drop [2];

  function automatic int div_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  // Slave drives bit k of the frame from stream[47-k] before the k-th rise.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      spi_miso[d] = 1'b0;
      if (rise_cnt[d] < 48)
        spi_miso[d] = stream[d][6'(47 - rise_cnt[d])];
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      logic empty;
      checks++;
      if (spi_cs_n[d] == 2'b00 || (spi_cs_n[d] == 2'b11 && spi_sck[d])) begin
        errors++;
        $display("FAIL bus_state d=%0d cs_n=%b sck=%b (need one cs low max, sck low when idle)",
                 d, spi_cs_n[d], spi_sck[d]);
      end
      if (spi_sck[d] && !prev_sck[d]) begin
        mosi_bits[d] = {mosi_bits[d][46:0], spi_mosi[d]};
        rise_cnt[d]++;
      end
      prev_sck[d] = spi_sck[d];
      cs_and[d] = cs_and[d] & spi_cs_n[d];
      if (!req_ready[d]) ready_drop[d] = 1'b1;
      if (resp_valid[d]) begin
        resp_cnt[d]++;
        empty = (d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
        checks++;
        if (empty) begin
          errors++;
          $display("FAIL resp_unexpected d=%0d cyc=%0d got resp_valid required none", d, cyc);
        end else begin
          e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          checks += 3;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL resp_cycle d=%0d got %0d required %0d", d, cyc, e.cyc);
          end
          if (resp_rdata[d] !== e.rdata) begin
            errors++;
            $display("FAIL resp_rdata d=%0d got %h required %h", d, resp_rdata[d], e.rdata);
          end
          if (req_ready[d] !== e.ready) begin
            errors++;
            $display("FAIL ready_at_resp d=%0d got %b required %b", d, req_ready[d], e.ready);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic clear_mon(input int d, input logic [47:0] s);
    mosi_bits[d]  = '0;
    rise_cnt[d]   = 0;
    cs_and[d]     = 2'b11;
    ready_drop[d] = 1'b0;
    stream[d]     = s;
  endtask

  task automatic drive(input vec_t v);
    req_write[v.d] = v.wr;
    req_size[v.d]  = v.sz;
    req_addr[v.d]  = v.addr;
    req_wdata[v.d] = v.wdata;
    req_valid[v.d] = 1'b1;
  endtask

  task automatic scramble(input int d);
    req_valid[d] = 1'b0;
    req_write[d] = 1'($urandom);
    req_size[d]  = 1'($urandom);
    req_addr[d]  = 22'($urandom);
    req_wdata[d] = 16'($urandom);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n;
    int   t;
    int   gap;
    @(posedge clk); #1;
    clear_mon(v.d, v.miso);
    @(negedge clk); #1;
    e.cyc   = cyc + 1 + 2 * div_of(v.d) * v.nbits;
    e.rdata = v.rdata;
    e.ready = (v.nbits == 0);
    if (v.d == 0) exp_q0.push_back(e);
    else          exp_q1.push_back(e);
    n = resp_cnt[v.d];
    drive(v);
    @(negedge clk); #1;
    scramble(v.d);
    t = 0;
    while (resp_cnt[v.d] == n && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL resp_timeout d=%0d got no resp required one", v.d);
    end
    gap = 0;
    while (!req_ready[v.d] && gap < 100) begin
      @(negedge clk); #1;
      gap++;
    end
    chk("gap_len", 48'(gap), 48'((v.nbits == 0) ? 0 : div_of(v.d)));
    chk("sck_rises", 48'(rise_cnt[v.d]), 48'(v.nbits));
    chk("mosi_frame", mosi_bits[v.d], v.mosi);
    chk("cs_select", 48'(cs_and[v.d]), 48'(v.cs));
    chk("rdata_hold", 48'(resp_rdata[v.d]), 48'(v.rdata));
    if (v.nbits == 0) chk("ready_kept", 48'(ready_drop[v.d]), 48'(0));
  endtask

  vec_t tbl[7];
  int   t;

  initial begin
    tbl[0] = '{0, 1'b0, 1'b1, 22'h200011, 16'h0000, 48'h3412,
               16'h1234, 2'b01, 48, 48'h03_000010_0000};
    tbl[1] = '{0, 1'b1, 1'b0, 22'h200005, 16'hCDAB, 48'h0,
               16'h1234, 2'b01, 40, 48'h02_000005_AB};
    tbl[2] = '{1, 1'b0, 1'b0, 22'h000100, 16'h0000, 48'h5A00,
               16'h005A, 2'b10, 40, 48'h03_000100_00};
    tbl[3] = '{1, 1'b1, 1'b0, 22'h000040, 16'h1111, 48'h0,
               16'h005A, 2'b11, 0, 48'h0};
    tbl[4] = '{0, 1'b1, 1'b1, 22'h3FFFFF, 16'hBEEF, 48'h0,
               16'h1234, 2'b01, 48, 48'h02_1FFFFE_EFBE};
    tbl[5] = '{1, 1'b0, 1'b0, 22'h3FFFFF, 16'h0000, 48'hC300,
               16'h00C3, 2'b01, 40, 48'h03_1FFFFF_00};
    tbl[6] = '{1, 1'b0, 1'b1, 22'h000003, 16'h0000, 48'h00FF,
               16'hFF00, 2'b10, 48, 48'h03_000002_0000};

    for (int d = 0; d < 2; d++) begin
      prev_sck[d] = 1'b0;
      resp_cnt[d] = 0;
      clear_mon(d, '0);
      scramble(d);
    end

    // Reset state with random inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        scramble(d);
        req_valid[d] = 1'($urandom);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        chk("rst_cs_n", 48'(spi_cs_n[d]), 48'(2'b11));
        chk("rst_sck", 48'(spi_sck[d]), 48'(0));
        chk("rst_mosi", 48'(spi_mosi[d]), 48'(0));
        chk("rst_resp_valid", 48'(resp_valid[d]), 48'(0));
        chk("rst_rdata", 48'(resp_rdata[d]), 48'(0));
      end
    end
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("ready_after_rst0", 48'(req_ready[0]), 48'(1));
    chk("ready_after_rst1", 48'(req_ready[1]), 48'(1));

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Abort a PSRAM read at bit 20; no response may follow.
    @(posedge clk); #1;
    clear_mon(0, tbl[0].miso);
    @(negedge clk); #1;
    drive(tbl[0]);
    @(negedge clk); #1;
    scramble(0);
    t = 0;
    while (rise_cnt[0] < 20 && t < 500) begin
      @(negedge clk); #1;
      t++;
    end
    chk("abort_reach_bit20", 48'(t < 500), 48'(1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 48'(spi_cs_n[0]), 48'(2'b11));
    chk("abort_sck", 48'(spi_sck[0]), 48'(0));
    t = resp_cnt[0];
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    chk("abort_no_resp", 48'(resp_cnt[0]), 48'(t));
    chk("abort_rdata_clr", 48'(resp_rdata[0]), 48'(0));
    run_vec(tbl[0]);

    chk("scoreboard_empty", 48'(exp_q0.size() + exp_q1.size()), 48'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
